// File: rtl/dmem_lat.sv
// rtl/dmem_lat.sv - RV32I data memory with configurable latency, handshake and stall
// One outstanding access; stores commit and loads sample on the edge entering DONE.
module dmem_lat #(
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  logic [31:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [2:0]  cap_f3;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  // With LATENCY=1 the commit edge is the accept edge, so the live request is used.
  logic        c_we;
  logic [2:0]  c_f3;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;

  always_comb begin
    c_we    = cap_we;
    c_f3    = cap_f3;
    c_addr  = cap_addr;
    c_wdata = cap_wdata;
    if (state == IDLE) begin
      c_we    = req_we;
      c_f3    = req_funct3;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end
  end

  logic          enter_done;
  logic          err;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   lane;
  logic [31:0]   ld_data;
  logic [31:0]   wdata_sh;
  logic [3:0]    be;

  assign enter_done = (state == IDLE && req_valid && LATENCY == 1) ||
                      (state == BUSY && cnt == 4'd0);
  assign idx      = c_addr[AW+1:2];
  assign rd_word  = mem[idx];
  assign lane     = rd_word >> {c_addr[1:0], 3'b000};
  assign wdata_sh = c_wdata << {c_addr[1:0], 3'b000};

  always_comb begin
    err = 1'b0;
    if (c_f3 == 3'd3 || c_f3 == 3'd6 || c_f3 == 3'd7) err = 1'b1;
    if (c_f3[2] && c_we) err = 1'b1;
    if (c_f3[1:0] == 2'd1 && c_addr[0]) err = 1'b1;
    if (c_f3[1:0] == 2'd2 && c_addr[1:0] != 2'd0) err = 1'b1;
    if ({2'b00, c_addr[31:2]} >= 32'(DEPTH)) err = 1'b1;
  end

  always_comb begin
    be = 4'b0000;
    case (c_f3[1:0])
      2'd0:    be = 4'b0001 << c_addr[1:0];
      2'd1:    be = 4'b0011 << {c_addr[1], 1'b0};
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    ld_data = '0;
    case (c_f3)
      3'd0:    ld_data = {{24{lane[7]}}, lane[7:0]};
      3'd1:    ld_data = {{16{lane[15]}}, lane[15:0]};
      3'd2:    ld_data = rd_word;
      3'd4:    ld_data = {24'd0, lane[7:0]};
      3'd5:    ld_data = {16'd0, lane[15:0]};
      default: ld_data = '0;
    endcase
    if (c_we || err) ld_data = '0;
  end

  assign stall = (state == BUSY) || (state == IDLE && req_valid);

  // Memory shares the reset-guarded block so a reset edge can never commit a store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cap_we     <= 1'b0;
      cap_f3     <= 3'd0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_f3    <= req_funct3;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state      <= DONE;
              resp_valid <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= 4'(LATENCY - 2);
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state      <= DONE;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
      if (enter_done) begin
        resp_rdata <= ld_data;
        resp_err   <= err;
        if (c_we && !err) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_lat.sv
// tb/tb_dmem_lat.sv - self-checking bench for dmem_lat at LATENCY 3, 1 and 4
// A byte-array reference model per instance predicts every response.
module tb_dmem_lat;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  int          sel;

  logic [2:0]       rdy_w, rv_w, err_w, st_w;
  logic [2:0][31:0] rd_w;

  int checks = 0;
  int errors = 0;
  int lat_of[3] = '{3, 1, 4};
  logic [7:0] mb [3][256];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 3 : ((g == 1) ? 1 : 4);
      logic v;
      assign v = req_valid && (sel == g);
      dmem_lat #(.DEPTH(64), .LATENCY(LAT), .INIT_FILE("")) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (v),
        .req_ready  (rdy_w[g]),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (rv_w[g]),
        .resp_rdata (rd_w[g]),
        .resp_err   (err_w[g]),
        .stall      (st_w[g])
      );
    end
  endgenerate

  function automatic void model(input int d, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic e, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    e = (f3 == 3 || f3 >= 6) || (f3 >= 4 && we) || (f3[1:0] == 1 && a[0]) ||
        (f3 == 2 && a[1:0] != 0) || (a / 4 >= 64);
    rd = 0;
    if (e) return;
    n = 1 << f3[1:0];
    if (we) begin
      for (int i = 0; i < n; i++) mb[d][a + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[d][a + i]) << (8 * i));
      if (f3 < 4 && n < 4 && v[8*n - 1]) v = v | ~((32'd1 << (8 * n)) - 1);
      rd = v;
    end
  endfunction

  task automatic access(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic use_lit, input logic [31:0] lit);
    logic e;
    logic [31:0] rd;
    bit seen;
    model(d, we, f3, a, wd, e, rd);
    sel = d;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    checks++;
    if (rdy_w[d] !== 1'b1 || st_w[d] !== 1'b1) begin
      errors++;
      $display("FAIL accept_flags: got ready=%b stall=%b want ready=1 stall=1", rdy_w[d], st_w[d]);
    end
    seen = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk); #1;
      if (n < lat_of[d]) begin
        req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end else begin
        req_valid = 0;
      end
      @(negedge clk);
      if (rv_w[d] === 1'b1) begin
        seen = 1;
        checks++;
        if (n != lat_of[d]) begin
          errors++;
          $display("FAIL latency: got %0d want %0d", n, lat_of[d]);
        end
        checks++;
        if (rd_w[d] !== rd) begin
          errors++;
          $display("FAIL rdata a=%h f3=%0d we=%b: got %h want %h", a, f3, we, rd_w[d], rd);
        end
        checks++;
        if (err_w[d] !== e) begin
          errors++;
          $display("FAIL err a=%h f3=%0d we=%b: got %b want %b", a, f3, we, err_w[d], e);
        end
        checks++;
        if (st_w[d] !== 1'b0 || rdy_w[d] !== 1'b0) begin
          errors++;
          $display("FAIL done_flags: got stall=%b ready=%b want 0 0", st_w[d], rdy_w[d]);
        end
        if (use_lit) begin
          checks++;
          if (rd_w[d] !== lit) begin
            errors++;
            $display("FAIL directed a=%h f3=%0d: got %h want %h", a, f3, rd_w[d], lit);
          end
        end
      end else begin
        checks++;
        if (st_w[d] !== 1'b1 || rdy_w[d] !== 1'b0) begin
          errors++;
          $display("FAIL busy_flags: got stall=%b ready=%b want 1 0", st_w[d], rdy_w[d]);
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_valid want one within 20 cycles");
    end
    req_valid = 0;
  endtask

  task automatic test_reset();
    reset = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; sel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rdy_w[d] !== 1'b1 || rv_w[d] !== 1'b0 || rd_w[d] !== 32'd0 ||
          err_w[d] !== 1'b0 || st_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got rdy=%b rv=%b rd=%h err=%b st=%b want 1 0 0 0 0",
                 d, rdy_w[d], rv_w[d], rd_w[d], err_w[d], st_w[d]);
      end
    end
    @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic test_directed();
    access(0, 1, 2, 32'h10, 32'hDEADBEEF, 1, 32'h0);
    access(0, 0, 2, 32'h10, 32'h0, 1, 32'hDEADBEEF);
    access(0, 1, 0, 32'h11, 32'h80, 1, 32'h0);
    access(0, 0, 0, 32'h11, 32'h0, 1, 32'hFFFFFF80);
    access(0, 0, 4, 32'h11, 32'h0, 1, 32'h00000080);
    access(0, 0, 2, 32'h10, 32'h0, 1, 32'hDEAD80EF);
    access(0, 0, 5, 32'h12, 32'h0, 1, 32'h0000DEAD);
  endtask

  task automatic test_errors();
    access(0, 1, 1, 32'h13, 32'h0000FFFF, 1, 32'h0);
    access(0, 0, 2, 32'h12, 32'h0, 1, 32'h0);
    access(0, 0, 3, 32'h10, 32'h0, 1, 32'h0);
    access(0, 0, 2, 32'h100, 32'h0, 1, 32'h0);
    access(0, 1, 4, 32'h10, 32'h11111111, 1, 32'h0);
    access(0, 1, 2, 32'h104, 32'h22222222, 1, 32'h0);
    access(0, 0, 2, 32'h10, 32'h0, 1, 32'hDEAD80EF);
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 32'h11F));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
      access(0, 1'($urandom), f3, a, $urandom, 0, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] exp [4];
    logic e;
    for (int i = 0; i < 4; i++) begin
      addrs[i] = 32'(4 * i + 32);
      access(1, 1, 2, addrs[i], $urandom, 0, 32'h0);
    end
    for (int i = 0; i < 4; i++) model(1, 0, 2, addrs[i], 0, e, exp[i]);
    sel = 1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      req_valid = 1; req_we = 0; req_funct3 = 2;
      req_addr = (c % 2 == 0) ? addrs[c / 2] : $urandom;
      @(negedge clk);
      checks++;
      if (rdy_w[1] !== 1'(c % 2 == 0) || st_w[1] !== 1'(c % 2 == 0) || rv_w[1] !== 1'(c % 2 == 1)) begin
        errors++;
        $display("FAIL b2b_flags c=%0d: got rdy=%b st=%b rv=%b want %b %b %b", c,
                 rdy_w[1], st_w[1], rv_w[1], 1'(c % 2 == 0), 1'(c % 2 == 0), 1'(c % 2 == 1));
      end
      if (c % 2 == 1) begin
        checks++;
        if (rd_w[1] !== exp[c / 2]) begin
          errors++;
          $display("FAIL b2b_rdata c=%0d: got %h want %h", c, rd_w[1], exp[c / 2]);
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 0;
    access(1, 1, 2, 32'h14, 32'hCAFEF00D, 1, 32'h0);
    access(1, 0, 1, 32'h16, 32'h0, 1, 32'hFFFFCAFE);
    access(1, 0, 1, 32'h14, 32'h0, 1, 32'hFFFFF00D);
  endtask

  task automatic test_reset_mid();
    sel = 2;
    @(posedge clk); #1;
    req_valid = 1; req_we = 1; req_funct3 = 2; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    checks++;
    if (st_w[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_stall: got %b want 1", st_w[2]);
    end
    reset = 0;
    #1;
    checks++;
    if (rdy_w[2] !== 1'b1 || st_w[2] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b st=%b want 1 0", rdy_w[2], st_w[2]);
    end
    @(negedge clk);
    reset = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (rv_w[2] !== 1'b0 || rdy_w[2] !== 1'b1) begin
        errors++;
        $display("FAIL post_reset c=%0d: got rv=%b rdy=%b want 0 1", c, rv_w[2], rdy_w[2]);
      end
    end
    access(2, 0, 2, 32'h20, 32'h0, 1, 32'h0);
    access(2, 1, 0, 32'h23, 32'h000000A5, 1, 32'h0);
    access(2, 0, 0, 32'h23, 32'h0, 1, 32'hFFFFFFA5);
  endtask

  initial begin
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 256; i++) mb[d][i] = 8'h00;
    test_reset();
    test_directed();
    test_errors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
